writeback_load_sequencer: RTL and testbench

//  Sequences the CPU writeback stage when a load is outstanding; replaces the always-ready writeback.

---
 rtl/writeback_load_sequencer_if.sv | 41 ++++
 rtl/writeback_load_sequencer.sv | 146 ++++++++++++++
 tb/tb_writeback_load_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/writeback_load_sequencer_if.sv
// ============================================================================
// Module : writeback_load_sequencer_if
// Brief  : Upstream instruction, memory return and commit bundle for writeback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface writeback_load_sequencer_if;
  logic        ready;
  logic        enable;
  logic [4:0]  rd;
  logic [31:0] next_pc;
  logic        rd_value_write_enable;
  logic [31:0] rd_value_write_data;
  logic        read_issued;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_low;
  logic        mem_read_data_valid;
  logic [31:0] mem_read_data;
  logic        pc_write_enable;
  logic [31:0] pc_write_data;
  logic        register_file_write_enable;
  logic [4:0]  register_file_write_addr;
  logic [31:0] register_file_write_data;

  modport slave (
    input  enable, rd, next_pc, rd_value_write_enable, rd_value_write_data,
           read_issued, load_funct3, load_addr_low, mem_read_data_valid, mem_read_data,
    output ready, pc_write_enable, pc_write_data, register_file_write_enable,
           register_file_write_addr, register_file_write_data
  );

  modport master (
    output enable, rd, next_pc, rd_value_write_enable, rd_value_write_data,
           read_issued, load_funct3, load_addr_low, mem_read_data_valid, mem_read_data,
    input  ready, pc_write_enable, pc_write_data, register_file_write_enable,
           register_file_write_addr, register_file_write_data
  );
endinterface

`default_nettype wire

// File: rtl/writeback_load_sequencer.sv
// ============================================================================
// Module : writeback_load_sequencer
// Brief  : Writeback stage that stalls on outstanding loads, formats load data
//          and retires PC and register file together.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module writeback_load_sequencer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  writeback_load_sequencer_if.slave   bus,
  output logic                        timeout_error,
  output logic                        protocol_error
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_READ = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [4:0]       lat_rd;
  logic [31:0]      lat_pc;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_addr_low;
  logic [CNT_W-1:0] wait_count;
  logic             load_accept;
  logic             load_park;

  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_low);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_low)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_low[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {24'd0, b};
      3'b101:  format_load = {16'd0, h};
      default: format_load = word;
    endcase
  endfunction

  assign load_accept = (state == IDLE) && bus.enable && bus.read_issued;
  assign load_park   = load_accept && !bus.mem_read_data_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (load_park) state_next = WAIT_READ;
      WAIT_READ: if (bus.mem_read_data_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready                      = (state == IDLE);
    bus.pc_write_enable            = 1'b0;
    bus.register_file_write_enable = 1'b0;
    bus.pc_write_data              = bus.next_pc;
    bus.register_file_write_addr   = bus.rd;
    bus.register_file_write_data   = bus.read_issued
                                   ? format_load(bus.mem_read_data, bus.load_funct3, bus.load_addr_low)
                                   : bus.rd_value_write_data;
    case (state)
      IDLE: begin
        if (bus.enable && !bus.read_issued) begin
          bus.pc_write_enable            = 1'b1;
          bus.register_file_write_enable = bus.rd_value_write_enable && (bus.rd != 5'd0);
        end else if (load_accept && bus.mem_read_data_valid) begin
          bus.pc_write_enable            = 1'b1;
          bus.register_file_write_enable = (bus.rd != 5'd0);
        end
      end
      WAIT_READ: begin
        // Upstream may already present the next instruction; only latched fields count.
        bus.pc_write_data              = lat_pc;
        bus.register_file_write_addr   = lat_rd;
        bus.register_file_write_data   = format_load(bus.mem_read_data, lat_funct3, lat_addr_low);
        bus.pc_write_enable            = bus.mem_read_data_valid;
        bus.register_file_write_enable = bus.mem_read_data_valid && (lat_rd != 5'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_rd         <= 5'd0;
      lat_pc         <= 32'd0;
      lat_funct3     <= 3'd0;
      lat_addr_low   <= 2'd0;
      wait_count     <= '0;
      timeout_error  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_count <= '0;
          if (load_park) begin
            lat_rd       <= bus.rd;
            lat_pc       <= bus.next_pc;
            lat_funct3   <= bus.load_funct3;
            lat_addr_low <= bus.load_addr_low;
          end
          if (bus.mem_read_data_valid && !load_accept) begin
            protocol_error <= 1'b1;
          end
        end
        WAIT_READ: begin
          if (bus.mem_read_data_valid) begin
            wait_count <= '0;
          end else if (wait_count == CNT_LAST) begin
            timeout_error <= 1'b1;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        default: wait_count <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_load_sequencer.sv
// ============================================================================
// Module : tb_writeback_load_sequencer
// Brief  : Directed plus randomized checks against a transaction-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_load_sequencer;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic timeout_error;
  logic protocol_error;
  int   checks = 0;
  int   errors = 0;
  logic exp_to = 1'b0;
  logic exp_pe = 1'b0;

  always #5 clk = ~clk;

  writeback_load_sequencer_if bus();

  writeback_load_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .timeout_error  (timeout_error),
    .protocol_error (protocol_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load formatting from plain shift/mask arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] a);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = (word >> (8 * a)) & 32'hFF;
                  if (v >= 32'd128) v = v + 32'hFFFF_FF00; end
      3'd1: begin v = (word >> (16 * a[1])) & 32'hFFFF;
                  if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'd4: v = (word >> (8 * a)) & 32'hFF;
      3'd5: v = (word >> (16 * a[1])) & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic exp_cycle(input string tag, input logic rdy, input logic pc_we,
                           input logic [31:0] pc, input logic rf_we, input logic [4:0] addr,
                           input logic [31:0] data);
    chk({tag, ".ready"}, 32'(bus.ready), 32'(rdy));
    chk({tag, ".pc_we"}, 32'(bus.pc_write_enable), 32'(pc_we));
    if (pc_we) chk({tag, ".pc_data"}, bus.pc_write_data, pc);
    chk({tag, ".rf_we"}, 32'(bus.register_file_write_enable), 32'(rf_we));
    if (rf_we) begin
      chk({tag, ".rf_addr"}, 32'(bus.register_file_write_addr), 32'(addr));
      chk({tag, ".rf_data"}, bus.register_file_write_data, data);
    end
    chk({tag, ".timeout"}, 32'(timeout_error), 32'(exp_to));
    chk({tag, ".protocol"}, 32'(protocol_error), 32'(exp_pe));
  endtask

  task automatic scramble_upstream();
    bus.rd                    = 5'($urandom);
    bus.next_pc               = $urandom;
    bus.rd_value_write_enable = 1'($urandom);
    bus.rd_value_write_data   = $urandom;
    bus.load_funct3           = 3'($urandom);
    bus.load_addr_low         = 2'($urandom);
    bus.mem_read_data         = $urandom;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    scramble_upstream();
    bus.enable = 1'b0; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b0;
    #1 exp_cycle(tag, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic nonload(input string tag, input logic [4:0] rd, input logic we,
                         input logic [31:0] data, input logic [31:0] pc);
    @(negedge clk);
    scramble_upstream();
    bus.enable = 1'b1; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b0;
    bus.rd = rd; bus.rd_value_write_enable = we; bus.rd_value_write_data = data; bus.next_pc = pc;
    #1 exp_cycle(tag, 1'b1, 1'b1, pc, we && (rd != 5'd0), rd, data);
  endtask

  // wait_n = 0: data returns in the issue cycle; otherwise in the wait_n-th stall cycle.
  task automatic load(input string tag, input logic [4:0] rd, input logic [31:0] pc,
                      input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word,
                      input int wait_n);
    logic [31:0] fmt;
    fmt = model_load(word, f3, a);
    @(negedge clk);
    scramble_upstream();
    bus.enable = 1'b1; bus.read_issued = 1'b1;
    bus.rd = rd; bus.next_pc = pc; bus.load_funct3 = f3; bus.load_addr_low = a;
    bus.mem_read_data_valid = (wait_n == 0);
    if (wait_n == 0) bus.mem_read_data = word;
    #1;
    if (wait_n == 0) exp_cycle(tag, 1'b1, 1'b1, pc, rd != 5'd0, rd, fmt);
    else             exp_cycle(tag, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= wait_n; k++) begin
      @(negedge clk);
      scramble_upstream();
      bus.enable = 1'($urandom); bus.read_issued = 1'($urandom);
      bus.mem_read_data_valid = (k == wait_n);
      if (k == wait_n) bus.mem_read_data = word;
      #1;
      if (k == wait_n) exp_cycle(tag, 1'b0, 1'b1, pc, rd != 5'd0, rd, fmt);
      else             exp_cycle(tag, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (k < wait_n && k >= T) exp_to = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b0;
    exp_to = 1'b0; exp_pe = 1'b0;
    #1 exp_cycle("reset", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    scramble_upstream();
    bus.enable = 1'b0; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b0;

    do_reset();
    nonload("t1_nonload", 5'd5, 1'b1, 32'h0000_1234, 32'h0000_0104);
    load("t2_lb_wait", 5'd3, 32'h0000_0200, 3'd0, 2'd2, 32'h0080_0000, 3);
    load("t3_lhu_zero", 5'd7, 32'h0000_0300, 3'd5, 2'd2, 32'hBEEF_0001, 0);
    load("t3_lh_zero", 5'd7, 32'h0000_0304, 3'd1, 2'd2, 32'hBEEF_0001, 0);
    load("t4_load_x0", 5'd0, 32'h0000_0400, 3'd2, 2'd0, 32'hDEAD_BEEF, 2);
    nonload("t4_nonload_x0", 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0000_0408);
    nonload("t4_nonload_nowe", 5'd9, 1'b0, 32'h1111_2222, 32'h0000_040C);
    load("t5_timeout", 5'd12, 32'h0000_0500, 3'd4, 2'd3, 32'h9A00_0000, 10);
    idle_cycle("t5_sticky");

    do_reset();
    @(negedge clk);
    scramble_upstream();
    bus.enable = 1'b0; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b1;
    #1 exp_cycle("t6_stray", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_pe = 1'b1;
    idle_cycle("t6_sticky");

    // Reset in the middle of a pending load.
    @(negedge clk);
    scramble_upstream();
    bus.enable = 1'b1; bus.read_issued = 1'b1; bus.mem_read_data_valid = 1'b0; bus.rd = 5'd9;
    #1 exp_cycle("t6_issue", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    #1 exp_cycle("t6_waiting", 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    exp_to = 1'b0; exp_pe = 1'b0;
    #1 exp_cycle("t6_mid_reset", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.enable = 1'b0; bus.read_issued = 1'b0; bus.mem_read_data_valid = 1'b1;
    #1 exp_cycle("t6_late_valid", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_pe = 1'b1;
    idle_cycle("t6_after");

    do_reset();
    repeat (150) begin
      if ($urandom_range(0, 2) == 0)
        nonload("rand_nonload", 5'($urandom), 1'($urandom), $urandom, $urandom);
      else
        load("rand_load", 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom,
             int'($urandom_range(0, 5)));
    end
    idle_cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
